tg_bus_arbiter: RTL and testbench
=================================

Name: tg_bus_arbiter

Overview:
- Round-robin arbiter that shares one transmission-gate tri-state line between N_REQ drivers.
- Produces the one-hot Control enables for the per-driver transmission gates.
- Never enables two gates at once. Inserts a break-before-make turnaround gap between owners.
- Enforces a maximum hold time, so no single driver can starve the others.

Parameters:
- N_REQ, 4, number of requesting drivers; legal range 2..16.
- TURNAROUND, 1, idle cycles with all gates off between owners; legal range ≥1.
- MAX_HOLD, 8, maximum consecutive DRIVE cycles per grant; 0 means unlimited.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  bit i high = driver i wants the line; level-sensitive, held while needed.
- control  output  N_REQ  one-hot-or-zero enable to the transmission gates; registered.
- owner_id  output  $clog2(N_REQ)  index of current owner; valid only when bus_busy=1.
- bus_busy  output  1  high while some gate is enabled.
- preempt  output  1  one-cycle pulse when a grant is ended by MAX_HOLD expiry.

Behaviour:
- Reset (async assert on rst_n low, sync-safe deassert): state=IDLE, control=0, owner_id=0, bus_busy=0, preempt=0, rr pointer=0 (driver 0 has highest priority), hold and turn counters=0.
- Asserting rst_n mid-DRIVE drops control to 0 immediately, without waiting for a clock edge.
- States:
  - IDLE: control=0.
  - DRIVE: control=onehot(owner).
  - TURN: control=0, for TURNAROUND cycles.
- IDLE -> DRIVE:
  - Condition: any req bit high at a clock edge.
  - control becomes the winner on that same edge, so latency is 1 cycle from req sampled to gate enabled.
- Round-robin pick:
  - Scan starts at index (rr pointer) and wraps modulo N_REQ.
  - First set req bit wins.
  - On grant, rr pointer = winner+1 (wraps N_REQ-1 -> 0).
- DRIVE -> TURN when either:
  - req[owner]=0 sampled: normal release, preempt stays 0.
  - MAX_HOLD≠0 and hold counter = MAX_HOLD-1: forced release; preempt=1 for the first TURN cycle.
  - If both are true on the same edge, the release counts as normal and preempt=0.
- Hold counter:
  - Width $clog2(MAX_HOLD+1).
  - Cleared on entry to DRIVE; increments each DRIVE cycle; saturates and never wraps.
- TURN exit:
  - After exactly TURNAROUND cycles with control=0, re-arbitrate on the edge ending TURN.
  - Any req high -> DRIVE with the new winner; otherwise -> IDLE.
  - A preempted owner still requesting is eligible, but is lowest priority (pointer moved past it).
- Simultaneous requests: exactly one winner per arbitration; others wait with no loss of request.
- Requests that toggle during TURN are ignored until the arbitration edge.
- Invariants (must hold every cycle):
  - popcount(control) ≤ 1.
  - bus_busy == |control.
  - Any change of owner has ≥TURNAROUND cycles of control=0 between the two owners.
- Single requester held continuously with MAX_HOLD=8:
  - Pattern repeats: 8 DRIVE cycles, TURNAROUND idle cycles, regrant.
- MAX_HOLD=0: owner keeps the line until it drops req; preempt never asserts.

Decomposition:
- Shared package tg_bus_pkg:
  - State enum (IDLE, DRIVE, TURN).
  - Function for $clog2-based index width.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req, pointer. Outputs: winner one-hot, winner index, any.
  - Reused by future tri-state bus controllers.
- Registers, counters and FSM stay in tg_bus_arbiter.

Test Plan:
- Reset checks:
  - Assert rst_n=0 while driver 2 is in DRIVE -> control=0 immediately, before the next edge.
  - Release reset with req=4'b0001 -> control=4'b0001 one edge later, owner_id=0.
- Contention, N_REQ=4, TURNAROUND=1: req=4'b1111 held, MAX_HOLD=8.
  - Grants in order 0,1,2,3,0.
  - Each owner holds 8 cycles, with 1 idle cycle between owners.
  - preempt pulses once per handoff.
- Normal release: driver 1 requests for 3 cycles, then drops.
  - 3 DRIVE cycles, then 1 TURN cycle, then IDLE.
  - preempt=0 throughout; bus_busy low from the TURN cycle.
- Wrap-around: pointer at 3 after granting driver 2, req=4'b0101 -> driver 0 wins (scan 3 -> 0).
- Race: req[owner] drops on the same edge the hold counter reaches MAX_HOLD-1 -> TURN entered, preempt=0.
- Invariant monitor across a 10k-cycle random req run:
  - popcount(control) ≤ 1 every cycle.
  - ≥TURNAROUND zero cycles at every owner change.
  - No requester waits more than (N_REQ-1)*(MAX_HOLD+TURNAROUND)+TURNAROUND cycles.

Source files
------------

// File: rtl/tg_bus_pkg.sv
// Shared types and helpers for the transmission-gate bus arbiter family.
// The state enum and index-width helper are reused by future tri-state bus controllers.
package tg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Index width that never collapses to zero bits, even for a count of one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after `pointer`
// (wrapping modulo N) wins and is returned both one-hot and as an index.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] pointer,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         any
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [W:0]     offset;
    logic [W:0]     sum;

    // Rotating the request vector puts the pointer position at bit 0.
    assign doubled = {req, req} >> pointer;
    assign rotated = doubled[N-1:0];

    always_comb begin
        offset = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (W+1)'(i);
                any    = 1'b1;
            end
        end
    end

    assign sum   = {1'b0, pointer} + offset;
    assign index = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];

    always_comb begin
        grant = '0;
        if (any) grant[index] = 1'b1;
    end

endmodule

// File: rtl/tg_bus_arbiter.sv
// Round-robin owner of one shared transmission-gate line: one-hot gate enables,
// break-before-make turnaround gap between owners, and an optional hold limit.
module tg_bus_arbiter
    import tg_bus_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         control,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     bus_busy,
    output logic                     preempt
);

    localparam int IW = idx_width(N_REQ);
    localparam int HW = idx_width(MAX_HOLD + 1);
    localparam int TW = idx_width(TURNAROUND + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

    state_t         state, state_d;
    logic [IW-1:0]  owner, owner_d;
    logic [IW-1:0]  ptr, ptr_d;
    logic [HW-1:0]  hold_cnt, hold_d;
    logic [TW-1:0]  turn_cnt, turn_d;
    logic [N_REQ-1:0] control_d;
    logic           preempt_d;
    logic           arbitrate;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_index;
    logic             pick_any;

    rr_pick #(
        .N (N_REQ),
        .W (IW)
    ) u_pick (
        .req     (req),
        .pointer (ptr),
        .grant   (pick_grant),
        .index   (pick_index),
        .any     (pick_any)
    );

    // A driver holds req high until served; control is its grant, and dropping
    // req while owning releases the line on the next edge.
    always_comb begin
        state_d   = state;
        owner_d   = owner;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        turn_d    = turn_cnt;
        control_d = control;
        preempt_d = 1'b0;
        arbitrate = 1'b0;

        unique case (state)
            IDLE: arbitrate = 1'b1;
            DRIVE: begin
                if (!req[owner]) begin
                    state_d   = TURN;
                    turn_d    = '0;
                    control_d = '0;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                    state_d   = TURN;
                    turn_d    = '0;
                    control_d = '0;
                    preempt_d = 1'b1;
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) arbitrate = 1'b1;
                else                       turn_d    = turn_cnt + 1'b1;
            end
            default: begin
                state_d   = IDLE;
                control_d = '0;
            end
        endcase

        if (arbitrate) begin
            if (pick_any) begin
                state_d   = DRIVE;
                owner_d   = pick_index;
                ptr_d     = (pick_index == LAST_IDX) ? '0 : pick_index + 1'b1;
                hold_d    = '0;
                control_d = pick_grant;
            end else begin
                state_d   = IDLE;
                control_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            control  <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            turn_cnt <= turn_d;
            control  <= control_d;
            preempt  <= preempt_d;
        end
    end

    assign owner_id = owner;
    assign bus_busy = |control;

endmodule

// File: tb/tb_tg_bus_arbiter.sv
// Bench for tg_bus_arbiter: directed scenarios plus a long random run checked
// against a rule-level model of ownership, gaps, hold limit and fairness.
module tb_tg_bus_arbiter;

    localparam int N     = 4;
    localparam int T     = 1;
    localparam int MH    = 8;
    localparam int BOUND = (N - 1) * (MH + T) + T;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] control;
    logic [1:0]   owner_id;
    logic         bus_busy;
    logic         preempt;

    int errors = 0;
    int checks = 0;

    tg_bus_arbiter #(
        .N_REQ      (N),
        .TURNAROUND (T),
        .MAX_HOLD   (MH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .control  (control),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Reference model: owner (-1 = nobody), remaining gap cycles, pointer, cycles held.
    int   m_owner;
    int   m_gap;
    int   m_ptr;
    int   m_held;
    logic m_pre;

    function automatic void model_reset();
        m_owner = -1;
        m_gap   = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (r[m_owner] == 1'b0) begin
                m_owner = -1;
                m_gap   = T;
            end else if (MH != 0 && m_held == MH) begin
                m_owner = -1;
                m_gap   = T;
                m_pre   = 1'b1;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_held  = 0;
                    m_ptr   = (idx + 1) % N;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] model_control();
        logic [N-1:0] one;
        one = 1;
        return (m_owner >= 0) ? (one << m_owner) : '0;
    endfunction

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (control !== 4'b0000) begin errors++; $display("FAIL reset_control: got %b want 0000", control); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
        checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b want 0", preempt); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
        req   = 4'b0001;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (control !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", control); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL first_owner: got %0d want 0", owner_id); end
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", bus_busy); end
        @(posedge clk);
        #1 req = 4'b0100;
        for (int i = 0; i < 10 && control !== 4'b0100; i++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (control !== 4'b0100) begin errors++; $display("FAIL grant_driver2: got %b want 0100", control); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (control !== 4'b0000) begin errors++; $display("FAIL async_reset_control: got %b want 0000", control); end
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", bus_busy); end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_hold();
        logic [N-1:0] exp_c;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_c = (c % (MH + T) < MH) ? 4'b0001 : 4'b0000;
            checks++; if (control !== exp_c) begin errors++; $display("FAIL single_hold_control c=%0d: got %b want %b", c, control, exp_c); end
            checks++; if (preempt !== (c % (MH + T) == MH)) begin errors++; $display("FAIL single_hold_preempt c=%0d: got %b want %b", c, preempt, (c % (MH + T) == MH)); end
        end
        req = '0;
    endtask

    task automatic test_contention();
        logic [N-1:0] one;
        logic [N-1:0] exp_c;
        int pulses;
        one    = 1;
        pulses = 0;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            exp_c = (c % (MH + T) < MH) ? (one << ((c / (MH + T)) % N)) : '0;
            if (preempt === 1'b1) pulses++;
            checks++; if (control !== exp_c) begin errors++; $display("FAIL contention_control c=%0d: got %b want %b", c, control, exp_c); end
            checks++; if (bus_busy !== (exp_c != 0)) begin errors++; $display("FAIL contention_busy c=%0d: got %b want %b", c, bus_busy, (exp_c != 0)); end
            if (exp_c != 0) begin
                checks++; if (owner_id !== 2'((c / (MH + T)) % N)) begin errors++; $display("FAIL contention_owner c=%0d: got %0d want %0d", c, owner_id, (c / (MH + T)) % N); end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL contention_pulses: got %0d want 4", pulses); end
        req = '0;
    endtask

    task automatic test_normal_release();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        checks++; if (control !== 4'b0010) begin errors++; $display("FAIL release_c1: got %b want 0010", control); end
        @(negedge clk);
        checks++; if (control !== 4'b0010) begin errors++; $display("FAIL release_c2: got %b want 0010", control); end
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        checks++; if (control !== 4'b0010 || preempt !== 1'b0) begin errors++; $display("FAIL release_c3: got %b/%b want 0010/0", control, preempt); end
        @(negedge clk);
        checks++; if (control !== 4'b0000 || bus_busy !== 1'b0 || preempt !== 1'b0) begin errors++; $display("FAIL release_turn: got %b/%b/%b want 0000/0/0", control, bus_busy, preempt); end
        @(negedge clk);
        checks++; if (control !== 4'b0000 || preempt !== 1'b0) begin errors++; $display("FAIL release_idle: got %b/%b want 0000/0", control, preempt); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (control !== 4'b0100) begin errors++; $display("FAIL wrap_grant2: got %b want 0100", control); end
        @(posedge clk);
        #1 req = '0;
        @(posedge clk);
        #1 req = 4'b0101;
        @(negedge clk);
        checks++; if (control !== 4'b0000) begin errors++; $display("FAIL wrap_turn: got %b want 0000", control); end
        @(negedge clk);
        checks++; if (control !== 4'b0001) begin errors++; $display("FAIL wrap_winner: got %b want 0001", control); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("FAIL wrap_owner: got %0d want 0", owner_id); end
        req = '0;
    endtask

    task automatic test_race();
        do_reset();
        req = 4'b0001;
        repeat (8) @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        checks++; if (control !== 4'b0001) begin errors++; $display("FAIL race_last_drive: got %b want 0001", control); end
        @(negedge clk);
        checks++; if (control !== 4'b0000) begin errors++; $display("FAIL race_turn_control: got %b want 0000", control); end
        checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL race_preempt: got %b want 0", preempt); end
        @(negedge clk);
        checks++; if (control !== 4'b0000 || preempt !== 1'b0) begin errors++; $display("FAIL race_idle: got %b/%b want 0000/0", control, preempt); end
    endtask

    task automatic test_random();
        int wait_cnt[N];
        int last_owner;
        int zero_run;
        int cur;
        logic [N-1:0] exp_c;
        do_reset();
        model_reset();
        last_owner = -1;
        zero_run   = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            model_step(req);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end else if (m_owner == i && $urandom_range(5) == 0) begin
                    req[i] = 1'b0;
                end
            end
            @(negedge clk);
            exp_c = model_control();
            checks++; if (control !== exp_c) begin errors++; if (errors < 50) $display("FAIL rand_control cyc=%0d: got %b want %b", cyc, control, exp_c); end
            checks++; if (preempt !== m_pre) begin errors++; if (errors < 50) $display("FAIL rand_preempt cyc=%0d: got %b want %b", cyc, preempt, m_pre); end
            checks++; if (bus_busy !== (|control)) begin errors++; if (errors < 50) $display("FAIL rand_busy cyc=%0d: got %b want %b", cyc, bus_busy, |control); end
            checks++; if ($countones(control) > 1) begin errors++; if (errors < 50) $display("FAIL rand_onehot cyc=%0d: got %b want at most one bit", cyc, control); end
            if (m_owner >= 0) begin
                checks++; if (owner_id !== 2'(m_owner)) begin errors++; if (errors < 50) $display("FAIL rand_owner cyc=%0d: got %0d want %0d", cyc, owner_id, m_owner); end
            end
            if (|control) begin
                cur = 0;
                for (int i = 0; i < N; i++) if (control[i]) cur = i;
                if (last_owner >= 0 && cur != last_owner) begin
                    checks++; if (zero_run < T) begin errors++; if (errors < 50) $display("FAIL rand_gap cyc=%0d: got %0d idle cycles want >= %0d", cyc, zero_run, T); end
                end
                last_owner = cur;
                zero_run   = 0;
            end else begin
                zero_run++;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i] && !control[i]) wait_cnt[i]++;
                else                       wait_cnt[i] = 0;
                if (wait_cnt[i] > 0) begin
                    checks++; if (wait_cnt[i] > BOUND) begin errors++; if (errors < 50) $display("FAIL rand_wait drv=%0d: got %0d cycles want <= %0d", i, wait_cnt[i], BOUND); end
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_contention();
        test_normal_release();
        test_wrap();
        test_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
